// File: rtl/chip_test_pkg.sv
// Shared types and defaults for the chip test sequencer.
package chip_test_pkg;

  localparam int unsigned DefNumChips      = 8;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitDone,
    StCapture,
    StRelease,
    StShow
  } state_e;

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronize the raw level and keep the previous synchronized value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// Runs one chip-tester slot per Start press: pulse Run, wait for Done or timeout, capture the
// verdict, release the tester and keep saturating pass/fail tallies.
module chip_test_sequencer
  import chip_test_pkg::*;
#(
  parameter int unsigned NUM_CHIPS      = DefNumChips,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [$clog2(NUM_CHIPS)-1:0] Chip_Sel,
  input  logic [NUM_CHIPS-1:0]         Done_vec,
  input  logic [NUM_CHIPS-1:0]         RSLT_vec,
  output logic [NUM_CHIPS-1:0]         Run_vec,
  output logic [NUM_CHIPS-1:0]         DISP_RSLT,
  output logic                         Busy,
  output logic                         Pass,
  output logic                         Timeout,
  output logic [7:0]                   Pass_Count,
  output logic [7:0]                   Fail_Count
);

  localparam int unsigned SelW = $clog2(NUM_CHIPS);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [SelW-1:0] sel_q;
  logic [CntW-1:0] cnt_q;
  logic            start_pulse;

  sync_edge_detect u_start_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .din   (Start),
    .pulse (start_pulse)
  );

  // Sequencer FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      Run_vec    <= '0;
      DISP_RSLT  <= '0;
      Busy       <= 1'b0;
      Pass       <= 1'b0;
      Timeout    <= 1'b0;
      Pass_Count <= 8'd0;
      Fail_Count <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_pulse) begin
            sel_q   <= Chip_Sel;
            cnt_q   <= '0;
            Run_vec <= NUM_CHIPS'(1) << Chip_Sel;
            Busy    <= 1'b1;
            state_q <= StArm;
          end
        end
        StArm: begin
          Run_vec <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          // Done is checked first so it wins over a coincident timeout.
          if (Done_vec[sel_q]) begin
            state_q <= StCapture;
          end else if (cnt_q == CntLast) begin
            Pass       <= 1'b0;
            Timeout    <= 1'b1;
            Fail_Count <= sat_inc(Fail_Count);
            Busy       <= 1'b0;
            state_q    <= StShow;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCapture: begin
          // One cycle after Done so the tester's registered RSLT has settled.
          Pass    <= RSLT_vec[sel_q];
          Timeout <= 1'b0;
          if (RSLT_vec[sel_q]) Pass_Count <= sat_inc(Pass_Count);
          else                 Fail_Count <= sat_inc(Fail_Count);
          DISP_RSLT <= NUM_CHIPS'(1) << sel_q;
          state_q   <= StRelease;
        end
        StRelease: begin
          if (!Done_vec[sel_q]) begin
            DISP_RSLT <= '0;
            Busy      <= 1'b0;
            state_q   <= StShow;
          end
        end
        StShow: begin
          state_q <= StIdle;
        end
        default: begin
          Run_vec   <= '0;
          DISP_RSLT <= '0;
          Busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Self-checking bench for chip_test_sequencer with a behavioural tester and verdict model.
module tb_chip_test_sequencer;

  localparam int unsigned NC = 8;
  localparam int unsigned TO = 1024;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] Chip_Sel;
  logic [7:0] Done_vec;
  logic [7:0] RSLT_vec;
  logic [7:0] Run_vec;
  logic [7:0] DISP_RSLT;
  logic       Busy;
  logic       Pass;
  logic       Timeout;
  logic [7:0] Pass_Count;
  logic [7:0] Fail_Count;

  int checks = 0;
  int errors = 0;

  // Reference model of the visible verdict state.
  int m_pass_cnt = 0;
  int m_fail_cnt = 0;
  bit m_pass     = 1'b0;
  bit m_to       = 1'b0;
  bit noise_en   = 1'b0;

  chip_test_sequencer #(
    .NUM_CHIPS      (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Chip_Sel   (Chip_Sel),
    .Done_vec   (Done_vec),
    .RSLT_vec   (RSLT_vec),
    .Run_vec    (Run_vec),
    .DISP_RSLT  (DISP_RSLT),
    .Busy       (Busy),
    .Pass       (Pass),
    .Timeout    (Timeout),
    .Pass_Count (Pass_Count),
    .Fail_Count (Fail_Count)
  );

  always #5 Clk = ~Clk;

  // One complete run: press Start, play the tester for slot sel, then compare against the model.
  task automatic do_run(input int sel, input int delay, input bit rslt, input bit never_done,
                        input int hold, input bit disturb, input string name);
    int   cyc = 0;
    int   run_cyc = -1;
    int   run_hi = 0;
    int   disp_hi = 0;
    int   disp_first = -1;
    int   show_cyc = -1;
    int   done_at = -1;
    bit   done_lvl = 1'b0;
    bit   busy_seen = 1'b0;
    bit   finished = 1'b0;
    bit   bad_run = 1'b0;
    bit   bad_disp = 1'b0;
    bit   post_bad = 1'b0;
    int   budget = delay + TO + 60;
    logic [7:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    @(negedge Clk);
    Chip_Sel = 3'(sel);
    Start    = 1'b1;
    while (!finished && cyc < budget) begin
      @(negedge Clk);
      cyc++;
      if (Run_vec != 8'h00) begin
        run_hi++;
        if (Run_vec !== oh) bad_run = 1'b1;
        if (run_cyc < 0) run_cyc = cyc;
      end
      if (DISP_RSLT != 8'h00) begin
        disp_hi++;
        if (DISP_RSLT !== oh) bad_disp = 1'b1;
        if (disp_first < 0) disp_first = cyc;
      end
      if (Busy) busy_seen = 1'b1;
      else if (busy_seen) begin
        show_cyc = cyc;
        finished = 1'b1;
      end
      // Tester: Done rises delay cycles after Run, RSLT settles one cycle later,
      // Done falls once the release strobe has been seen for hold cycles.
      if (run_cyc > 0 && !never_done && cyc == run_cyc + delay) begin
        done_lvl = 1'b1;
        done_at  = cyc;
      end
      if (done_lvl && disp_hi == hold) done_lvl = 1'b0;
      if (cyc == 4) Start = 1'b0;
      if (disturb && run_cyc > 0 && cyc == run_cyc + 2) begin
        Start    = 1'b1;
        Chip_Sel = 3'd5;
      end
      if (disturb && run_cyc > 0 && cyc == run_cyc + 5) Start = 1'b0;
      Done_vec = noise_en ? 8'($urandom) : 8'h00;
      RSLT_vec = noise_en ? 8'($urandom) : 8'h00;
      Done_vec[sel] = done_lvl;
      RSLT_vec[sel] = (done_at >= 0 && cyc > done_at) ? rslt : ~rslt;
    end
    Done_vec = 8'h00;
    RSLT_vec = 8'h00;
    Start    = 1'b0;

    if (never_done) begin
      m_fail_cnt = (m_fail_cnt < 255) ? m_fail_cnt + 1 : 255;
      m_pass     = 1'b0;
      m_to       = 1'b1;
    end else begin
      if (rslt) m_pass_cnt = (m_pass_cnt < 255) ? m_pass_cnt + 1 : 255;
      else      m_fail_cnt = (m_fail_cnt < 255) ? m_fail_cnt + 1 : 255;
      m_pass = rslt;
      m_to   = 1'b0;
    end

    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL %s show_reached: got %0d required 1 within %0d cycles", name, finished, budget);
    end
    checks++;
    if (run_hi !== 1 || bad_run) begin
      errors++;
      $display("FAIL %s run_pulse: got %0d cycles (wrong_slot=%0d) required 1 cycle on %h",
               name, run_hi, bad_run, oh);
    end
    checks++;
    if (run_cyc !== 3) begin
      errors++;
      $display("FAIL %s start_latency: got %0d required 3", name, run_cyc);
    end
    if (never_done) begin
      checks++;
      if (disp_hi !== 0) begin
        errors++;
        $display("FAIL %s disp_on_timeout: got %0d cycles required 0", name, disp_hi);
      end
      checks++;
      if (show_cyc !== run_cyc + 1 + int'(TO)) begin
        errors++;
        $display("FAIL %s timeout_len: got %0d required %0d", name, show_cyc,
                 run_cyc + 1 + int'(TO));
      end
    end else begin
      checks++;
      if (disp_first !== run_cyc + delay + 2 || bad_disp) begin
        errors++;
        $display("FAIL %s disp_start: got %0d (wrong_slot=%0d) required %0d", name, disp_first,
                 bad_disp, run_cyc + delay + 2);
      end
      checks++;
      if (disp_hi !== hold) begin
        errors++;
        $display("FAIL %s disp_len: got %0d required %0d", name, disp_hi, hold);
      end
    end
    checks++;
    if (Pass !== m_pass || Timeout !== m_to) begin
      errors++;
      $display("FAIL %s verdict: got pass=%b timeout=%b required pass=%b timeout=%b", name,
               Pass, Timeout, m_pass, m_to);
    end
    checks++;
    if (Pass_Count !== 8'(m_pass_cnt) || Fail_Count !== 8'(m_fail_cnt)) begin
      errors++;
      $display("FAIL %s counts: got pass=%0d fail=%0d required pass=%0d fail=%0d", name,
               Pass_Count, Fail_Count, m_pass_cnt, m_fail_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (Run_vec !== 8'h00 || DISP_RSLT !== 8'h00 || Busy !== 1'b0 || Pass !== m_pass ||
          Timeout !== m_to) post_bad = 1'b1;
    end
    checks++;
    if (post_bad) begin
      errors++;
      $display("FAIL %s idle_hold: got run=%h disp=%h busy=%b pass=%b to=%b required idle/held",
               name, Run_vec, DISP_RSLT, Busy, Pass, Timeout);
    end
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    Start    = 1'b0;
    Chip_Sel = 3'd0;
    Done_vec = 8'h00;
    RSLT_vec = 8'h00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (Run_vec !== 8'h00 || DISP_RSLT !== 8'h00 || Busy !== 1'b0 || Pass !== 1'b0 ||
        Timeout !== 1'b0 || Pass_Count !== 8'd0 || Fail_Count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got run=%h disp=%h busy=%b pass=%b to=%b pc=%0d fc=%0d required all 0",
               Run_vec, DISP_RSLT, Busy, Pass, Timeout, Pass_Count, Fail_Count);
    end
  endtask

  task automatic test_pass();
    do_run(3, 10, 1'b1, 1'b0, 3, 1'b0, "pass_slot3");
  endtask

  task automatic test_fail();
    do_run(3, 10, 1'b0, 1'b0, 2, 1'b0, "fail_slot3");
  endtask

  task automatic test_timeout();
    do_run(3, 0, 1'b0, 1'b1, 1, 1'b0, "timeout");
  endtask

  task automatic test_start_ignored();
    do_run(3, 12, 1'b1, 1'b0, 2, 1'b1, "start_ignored");
  endtask

  task automatic test_random();
    noise_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_run(int'($urandom_range(0, 7)), int'($urandom_range(1, 20)), 1'($urandom),
             1'b0, int'($urandom_range(1, 6)), 1'b0, "random");
    end
  endtask

  task automatic test_reset_in_release();
    int  cyc = 0;
    bit  seen = 1'b0;
    int  sel = int'($urandom_range(0, 7));
    logic [7:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    @(negedge Clk);
    Chip_Sel = 3'(sel);
    Start    = 1'b1;
    while (!seen && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 4) Start = 1'b0;
      if (cyc == 6) begin
        Done_vec = oh;
        RSLT_vec = oh;
      end
      if (DISP_RSLT === oh) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_release_reach: got disp=%h required %h within 100 cycles", DISP_RSLT, oh);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (DISP_RSLT !== 8'h00 || Run_vec !== 8'h00 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_outputs: got disp=%h run=%h busy=%b required 0", DISP_RSLT,
               Run_vec, Busy);
    end
    checks++;
    if (Pass !== 1'b0 || Timeout !== 1'b0 || Pass_Count !== 8'd0 || Fail_Count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async_verdict: got pass=%b to=%b pc=%0d fc=%0d required 0", Pass,
               Timeout, Pass_Count, Fail_Count);
    end
    Done_vec = 8'h00;
    RSLT_vec = 8'h00;
    @(negedge Clk);
    Reset = 1'b0;
    m_pass_cnt = 0;
    m_fail_cnt = 0;
    m_pass     = 1'b0;
    m_to       = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      do_run(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'b1, 1'b0, 1, 1'b0,
             "sat_pass");
    end
    checks++;
    if (Pass_Count !== 8'd255) begin
      errors++;
      $display("FAIL pass_saturate: got %0d required 255", Pass_Count);
    end
    for (int i = 0; i < 256; i++) begin
      do_run(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'b0, 1'b0, 1, 1'b0,
             "sat_fail");
    end
    checks++;
    if (Fail_Count !== 8'd255 || Pass_Count !== 8'd255) begin
      errors++;
      $display("FAIL fail_saturate: got fail=%0d pass=%0d required 255/255", Fail_Count,
               Pass_Count);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_start_ignored();
    test_random();
    test_reset_in_release();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
